tile_pixel_updater: RTL and testbench



---
 rtl/tile_pixel_updater.sv | 256 +++++++++++++++++++++++++
 tb/tb_tile_pixel_updater.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_pixel_updater.sv
// 8080-style LCD writer: runs the power-up command sequence, then paints one grid
// cell per request as a TILE_PX x TILE_PX square of RGB565 colour.
module tile_pixel_updater #(
   parameter int unsigned GRID_BITS  = 4,
   parameter int unsigned TILE_PX    = 16,
   parameter int unsigned WR_HALF    = 1,
   parameter int unsigned INIT_DELAY = 1200000
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 init_cycle,
   input  logic                 en_update,
   input  logic [GRID_BITS-1:0] x,
   input  logic [GRID_BITS-1:0] y,
   input  logic [2:0]           obj_code,
   output logic                 wr,
   output logic                 dcx,
   output logic [7:0]           D,
   output logic                 cmd_done,
   output logic                 busy
);

   localparam int unsigned TW     = $clog2(2*WR_HALF+1);
   localparam int unsigned WW     = $clog2(INIT_DELAY+WR_HALF+1);
   localparam int unsigned NPIX   = TILE_PX*TILE_PX;
   localparam int unsigned PCW    = $clog2(NPIX+1);
   localparam logic [15:0] TILE16 = 16'(TILE_PX);

   typedef enum logic [2:0] {
      IDLE, INIT_CMD, INIT_WAIT, SET_COL, SET_ROW, RAMWR, PIXELS, DONE
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           step_q, step_d;
   logic [TW-1:0]        tmr_q, tmr_d, tmr_nx;
   logic [WW-1:0]        wcnt_q, wcnt_d;
   logic [PCW-1:0]       pix_q, pix_d;
   logic [GRID_BITS-1:0] x_q, x_d, y_q, y_d;
   logic [2:0]           obj_q, obj_d;
   logic                 init_q, init_d;
   logic                 wr_q, wr_d, dcx_q, dcx_d, done_q, done_d, busy_q, busy_d;
   logic [7:0]           d_q, d_d;
   logic                 load, byte_end, sending;
   logic [15:0]          cs, ce, rs, re, colour;

   function automatic logic [15:0] palette(input logic [2:0] code);
      case (code)
         3'd0:    palette = 16'h0000;
         3'd1:    palette = 16'hFFFF;
         3'd2:    palette = 16'hF800;
         3'd3:    palette = 16'h07E0;
         3'd4:    palette = 16'h001F;
         3'd5:    palette = 16'hFFE0;
         3'd6:    palette = 16'h07FF;
         default: palette = 16'hF81F;
      endcase
   endfunction

   // {dcx, byte} sent at step stp of state st
   function automatic logic [8:0] byte_of(input state_t st, input logic [2:0] stp,
                                          input logic [15:0] c0, input logic [15:0] c1,
                                          input logic [15:0] r0, input logic [15:0] r1,
                                          input logic [15:0] col);
      logic [8:0] b;
      b = 9'h100;
      case (st)
         INIT_CMD: case (stp)
            3'd0:    b = {1'b0, 8'h01};
            3'd1:    b = {1'b0, 8'h11};
            3'd2:    b = {1'b0, 8'h3A};
            3'd3:    b = {1'b1, 8'h55};
            default: b = {1'b0, 8'h29};
         endcase
         SET_COL: case (stp)
            3'd0:    b = {1'b0, 8'h2A};
            3'd1:    b = {1'b1, c0[15:8]};
            3'd2:    b = {1'b1, c0[7:0]};
            3'd3:    b = {1'b1, c1[15:8]};
            default: b = {1'b1, c1[7:0]};
         endcase
         SET_ROW: case (stp)
            3'd0:    b = {1'b0, 8'h2B};
            3'd1:    b = {1'b1, r0[15:8]};
            3'd2:    b = {1'b1, r0[7:0]};
            3'd3:    b = {1'b1, r1[15:8]};
            default: b = {1'b1, r1[7:0]};
         endcase
         RAMWR:   b = {1'b0, 8'h2C};
         PIXELS:  b = stp[0] ? {1'b1, col[7:0]} : {1'b1, col[15:8]};
         default: b = 9'h100;
      endcase
      return b;
   endfunction

   assign cs     = 16'(x_q) * TILE16;
   assign ce     = cs + TILE16 - 16'd1;
   assign rs     = 16'(y_q) * TILE16;
   assign re     = rs + TILE16 - 16'd1;
   assign colour = palette(obj_q);

   // Sequencer and byte sender: a new byte is loaded on the last cycle of the previous one
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      wcnt_d   = wcnt_q;
      pix_d    = pix_q;
      x_d      = x_q;
      y_d      = y_q;
      obj_d    = obj_q;
      init_d   = init_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      wr_d     = 1'b1;
      dcx_d    = dcx_q;
      d_d      = d_q;
      tmr_d    = tmr_q;
      load     = 1'b0;
      sending  = 1'b0;
      tmr_nx   = tmr_q + TW'(1);
      byte_end = (tmr_q == TW'(2*WR_HALF-1));

      case (state_q)
         IDLE: begin
            if (init_cycle) begin
               state_d = INIT_CMD;
               step_d  = 3'd0;
               load    = 1'b1;
               busy_d  = 1'b1;
            end else if (en_update && init_q) begin
               state_d = SET_COL;
               step_d  = 3'd0;
               load    = 1'b1;
               busy_d  = 1'b1;
               x_d     = x;
               y_d     = y;
               obj_d   = obj_code;
            end
         end
         INIT_CMD: begin
            sending = 1'b1;
            if (byte_end) begin
               if (step_q == 3'd0 || step_q == 3'd1) begin
                  state_d = INIT_WAIT;
                  step_d  = step_q + 3'd1;
                  wcnt_d  = '0;
               end else if (step_q == 3'd4) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  init_d  = 1'b1;
               end else begin
                  step_d = step_q + 3'd1;
                  load   = 1'b1;
               end
            end
         end
         // Pause spans INIT_DELAY plus one wr half-period of settling after the command
         INIT_WAIT: begin
            if (wcnt_q == WW'(INIT_DELAY+WR_HALF-1)) begin
               state_d = INIT_CMD;
               load    = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         SET_COL, SET_ROW: begin
            sending = 1'b1;
            if (byte_end) begin
               load = 1'b1;
               if (step_q == 3'd4) begin
                  state_d = (state_q == SET_COL) ? SET_ROW : RAMWR;
                  step_d  = 3'd0;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
         end
         RAMWR: begin
            sending = 1'b1;
            if (byte_end) begin
               state_d = PIXELS;
               step_d  = 3'd0;
               pix_d   = '0;
               load    = 1'b1;
            end
         end
         PIXELS: begin
            sending = 1'b1;
            if (byte_end) begin
               if (step_q[0] && pix_q == PCW'(NPIX-1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  if (step_q[0]) pix_d = pix_q + PCW'(1);
                  step_d = {2'b00, ~step_q[0]};
                  load   = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         {dcx_d, d_d} = byte_of(state_d, step_d, cs, ce, rs, re, colour);
         tmr_d        = '0;
         wr_d         = 1'b0;
      end else if (sending) begin
         tmr_d = tmr_nx;
         wr_d  = (tmr_nx >= TW'(WR_HALF));
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= IDLE;
         step_q  <= '0;
         tmr_q   <= '0;
         wcnt_q  <= '0;
         pix_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         obj_q   <= '0;
         init_q  <= 1'b0;
         wr_q    <= 1'b1;
         dcx_q   <= 1'b1;
         d_q     <= 8'h00;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         tmr_q   <= tmr_d;
         wcnt_q  <= wcnt_d;
         pix_q   <= pix_d;
         x_q     <= x_d;
         y_q     <= y_d;
         obj_q   <= obj_d;
         init_q  <= init_d;
         wr_q    <= wr_d;
         dcx_q   <= dcx_d;
         d_q     <= d_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign wr       = wr_q;
   assign dcx      = dcx_q;
   assign D        = d_q;
   assign cmd_done = done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_tile_pixel_updater.sv
// Directed bench for tile_pixel_updater: a 4-pixel-tile instance (WR_HALF=1) and a
// 16-pixel-tile instance (WR_HALF=3), bytes captured on each wr rising edge.
module tb_tile_pixel_updater;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       nrst_a, init_a, upd_a, wr_a, dcx_a, done_a, busy_a;
   logic [3:0] x_a, y_a;
   logic [2:0] obj_a;
   logic [7:0] d_a;
   logic       nrst_b, init_b, upd_b, wr_b, dcx_b, done_b, busy_b;
   logic [3:0] x_b, y_b;
   logic [2:0] obj_b;
   logic [7:0] d_b;

   tile_pixel_updater #(.GRID_BITS(4), .TILE_PX(4), .WR_HALF(1), .INIT_DELAY(10)) dut_a (
      .clk(clk), .nrst(nrst_a), .init_cycle(init_a), .en_update(upd_a),
      .x(x_a), .y(y_a), .obj_code(obj_a),
      .wr(wr_a), .dcx(dcx_a), .D(d_a), .cmd_done(done_a), .busy(busy_a));

   tile_pixel_updater #(.GRID_BITS(4), .TILE_PX(16), .WR_HALF(3), .INIT_DELAY(10)) dut_b (
      .clk(clk), .nrst(nrst_b), .init_cycle(init_b), .en_update(upd_b),
      .x(x_b), .y(y_b), .obj_code(obj_b),
      .wr(wr_b), .dcx(dcx_b), .D(d_b), .cmd_done(done_b), .busy(busy_b));

   int checks = 0;
   int failures = 0;

   int         cyc = 0;
   logic [8:0] cap_a[$], cap_b[$];
   int         capc_a[$], capc_b[$];
   int         done_cnt_a = 0, done_at_a = 0, rise_at_a = 0, busy_cyc_a = 0;
   int         done_cnt_b = 0, done_at_b = 0, rise_at_b = 0;
   logic       wrp_a = 1'b1, bsp_a = 1'b0, wrp_b = 1'b1, bsp_b = 1'b0;
   logic       phase_en_b = 1'b0, seen_low_b = 1'b0, wr_last_b = 1'b1;
   int         run_b = 0, ph_cnt_b = 0, bad_ph_b = 0;

   // Monitor: byte capture on wr rise, busy rise / cmd_done timestamps, wr phase lengths
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!wrp_a && wr_a) begin cap_a.push_back({dcx_a, d_a}); capc_a.push_back(cyc); end
      if (!wrp_b && wr_b) begin cap_b.push_back({dcx_b, d_b}); capc_b.push_back(cyc); end
      wrp_a <= wr_a;
      wrp_b <= wr_b;
      if (busy_a && !bsp_a) rise_at_a <= cyc;
      if (busy_b && !bsp_b) rise_at_b <= cyc;
      bsp_a <= busy_a;
      bsp_b <= busy_b;
      if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
      if (done_a) begin done_cnt_a <= done_cnt_a + 1; done_at_a <= cyc; end
      if (done_b) begin done_cnt_b <= done_cnt_b + 1; done_at_b <= cyc; end
      if (!phase_en_b) seen_low_b <= 1'b0;
      if (wr_b == wr_last_b) begin
         run_b <= run_b + 1;
      end else begin
         if (phase_en_b && (!wr_last_b || seen_low_b)) begin
            ph_cnt_b <= ph_cnt_b + 1;
            if (run_b != 3) bad_ph_b <= bad_ph_b + 1;
         end
         if (phase_en_b && !wr_last_b) seen_low_b <= 1'b1;
         run_b     <= 1;
         wr_last_b <= wr_b;
      end
   end

   task automatic wait_busy_a(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (busy_a === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_done_a(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (done_cnt_a >= target) ok = 1'b1;
      end
   endtask

   task automatic wait_busy_b(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (busy_b === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_done_b(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (done_cnt_b >= target) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      int base, bd, bb;
      nrst_a = 1'b0; init_a = 1'b0; upd_a = 1'b0; x_a = '0; y_a = '0; obj_a = '0;
      nrst_b = 1'b0; init_b = 1'b0; upd_b = 1'b0; x_b = '0; y_b = '0; obj_b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({wr_a, dcx_a, d_a, done_a, busy_a} !== 12'hC00) begin
         failures++;
         $display("FAIL reset_a: {wr,dcx,D,done,busy}=%h expected c00", {wr_a, dcx_a, d_a, done_a, busy_a});
      end
      checks++;
      if ({wr_b, dcx_b, d_b, done_b, busy_b} !== 12'hC00) begin
         failures++;
         $display("FAIL reset_b: {wr,dcx,D,done,busy}=%h expected c00", {wr_b, dcx_b, d_b, done_b, busy_b});
      end
      nrst_a = 1'b1; nrst_b = 1'b1;
      @(negedge clk);
      base = cap_a.size(); bd = done_cnt_a; bb = busy_cyc_a;
      upd_a = 1'b1; x_a = 4'd2;
      repeat (4) @(negedge clk);
      upd_a = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (cap_a.size() - base != 0 || busy_cyc_a != bb) begin
         failures++;
         $display("FAIL uninit_update: bytes=%0d busy_cycles=%0d expected 0 and 0", cap_a.size() - base, busy_cyc_a - bb);
      end
      checks++;
      if (done_cnt_a != bd) begin
         failures++;
         $display("FAIL uninit_done: cmd_done cycles=%0d expected 0", done_cnt_a - bd);
      end
   endtask

   task automatic test_init_a();
      int base, bd;
      bit ok;
      logic [8:0] exp_init [5];
      int errs;
      exp_init = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h029};
      base = cap_a.size(); bd = done_cnt_a;
      @(negedge clk);
      init_a = 1'b1;
      wait_busy_a(20, ok);
      init_a = 1'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL init_accept: busy=%b expected 1", busy_a); end
      wait_done_a(bd + 1, 200, ok);
      repeat (5) @(negedge clk);
      checks++;
      if (!ok || done_cnt_a - bd != 1) begin
         failures++;
         $display("FAIL init_done: cmd_done cycles=%0d expected 1", done_cnt_a - bd);
      end
      errs = 0;
      for (int i = 0; i < 5; i++) if (cap_a[base+i] !== exp_init[i]) errs++;
      checks++;
      if (cap_a.size() - base != 5 || errs != 0) begin
         failures++;
         $display("FAIL init_bytes: count=%0d wrong=%0d first=%h expected 5 bytes 0 wrong first=001", cap_a.size() - base, errs, cap_a[base]);
      end
      checks++;
      if (capc_a[base+1] - capc_a[base] != 13 || capc_a[base+2] - capc_a[base+1] != 13) begin
         failures++;
         $display("FAIL init_gaps: %0d and %0d cycles expected 13 and 13", capc_a[base+1] - capc_a[base], capc_a[base+2] - capc_a[base+1]);
      end
      checks++;
      if (done_at_a - rise_at_a != 32) begin
         failures++;
         $display("FAIL init_latency: got %0d expected 32", done_at_a - rise_at_a);
      end
   endtask

   task automatic test_update_a();
      int base, bd, errs, first;
      bit ok;
      logic [8:0] expq[$];
      expq = '{9'h02A, 9'h100, 9'h104, 9'h100, 9'h107,
               9'h02B, 9'h100, 9'h108, 9'h100, 9'h10B, 9'h02C};
      for (int i = 0; i < 16; i++) begin expq.push_back(9'h107); expq.push_back(9'h1E0); end
      base = cap_a.size(); bd = done_cnt_a;
      @(negedge clk);
      x_a = 4'd1; y_a = 4'd2; obj_a = 3'd3; upd_a = 1'b1;
      wait_busy_a(20, ok);
      upd_a = 1'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL update_accept: busy=%b expected 1", busy_a); end
      repeat (10) @(negedge clk);
      x_a = 4'hF; y_a = 4'h0; obj_a = 3'd0;
      wait_done_a(bd + 1, 300, ok);
      repeat (4) @(negedge clk);
      checks++;
      if (!ok || done_cnt_a - bd != 1) begin
         failures++;
         $display("FAIL update_done: cmd_done cycles=%0d expected 1", done_cnt_a - bd);
      end
      errs = 0; first = -1;
      for (int i = 0; i < 43; i++) if (cap_a[base+i] !== expq[i]) begin errs++; if (first < 0) first = i; end
      checks++;
      if (cap_a.size() - base != 43 || errs != 0) begin
         failures++;
         $display("FAIL update_bytes: count=%0d wrong=%0d first_bad_idx=%0d expected 43 bytes 0 wrong", cap_a.size() - base, errs, first);
      end
      checks++;
      if (done_at_a - rise_at_a != 86) begin
         failures++;
         $display("FAIL update_latency: got %0d expected 86", done_at_a - rise_at_a);
      end
   endtask

   task automatic test_simultaneous_a();
      int base, bd;
      bit ok1, ok2, ok3, ok4;
      base = cap_a.size(); bd = done_cnt_a;
      @(negedge clk);
      x_a = 4'd0; y_a = 4'd0; obj_a = 3'd2; init_a = 1'b1; upd_a = 1'b1;
      wait_busy_a(20, ok1);
      init_a = 1'b0;
      wait_done_a(bd + 1, 200, ok2);
      wait_busy_a(10, ok3);
      upd_a = 1'b0;
      wait_done_a(bd + 2, 300, ok4);
      repeat (4) @(negedge clk);
      checks++;
      if (!(ok1 && ok2 && ok3 && ok4) || done_cnt_a - bd != 2) begin
         failures++;
         $display("FAIL simul_done: cmd_done cycles=%0d waits=%b%b%b%b expected 2 and 1111", done_cnt_a - bd, ok1, ok2, ok3, ok4);
      end
      checks++;
      if (cap_a.size() - base != 48 || cap_a[base] !== 9'h001 || cap_a[base+4] !== 9'h029) begin
         failures++;
         $display("FAIL simul_init_first: count=%0d b0=%h b4=%h expected 48 001 029", cap_a.size() - base, cap_a[base], cap_a[base+4]);
      end
      checks++;
      if (cap_a[base+5] !== 9'h02A || cap_a[base+9] !== 9'h103 || cap_a[base+16] !== 9'h1F8 || cap_a[base+47] !== 9'h100) begin
         failures++;
         $display("FAIL simul_update: %h %h %h %h expected 02a 103 1f8 100", cap_a[base+5], cap_a[base+9], cap_a[base+16], cap_a[base+47]);
      end
   endtask

   task automatic test_reset_mid_a();
      int base, bd;
      bit ok, ok2;
      base = cap_a.size(); bd = done_cnt_a;
      @(negedge clk);
      x_a = 4'd3; y_a = 4'd3; obj_a = 3'd5; upd_a = 1'b1;
      wait_busy_a(20, ok);
      upd_a = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (cap_a.size() >= base + 16) ok = 1'b1;
      end
      checks++;
      if (!ok || cap_a[base+15] !== 9'h1FF) begin
         failures++;
         $display("FAIL mid_5th_pixel: reached=%b byte=%h expected 1 1ff", ok, cap_a[base+15]);
      end
      nrst_a = 1'b0;
      @(negedge clk);
      checks++;
      if ({wr_a, dcx_a, d_a, done_a, busy_a} !== 12'hC00) begin
         failures++;
         $display("FAIL mid_reset_vals: {wr,dcx,D,done,busy}=%h expected c00", {wr_a, dcx_a, d_a, done_a, busy_a});
      end
      @(negedge clk);
      nrst_a = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt_a != bd) begin
         failures++;
         $display("FAIL mid_no_done: cmd_done cycles=%0d expected 0", done_cnt_a - bd);
      end
      base = cap_a.size();
      upd_a = 1'b1;
      repeat (4) @(negedge clk);
      upd_a = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (cap_a.size() != base || done_cnt_a != bd) begin
         failures++;
         $display("FAIL mid_uninit: bytes=%0d done=%0d expected 0 0", cap_a.size() - base, done_cnt_a - bd);
      end
      init_a = 1'b1;
      wait_busy_a(20, ok);
      init_a = 1'b0;
      wait_done_a(bd + 1, 200, ok2);
      base = cap_a.size();
      x_a = 4'd0; y_a = 4'd1; obj_a = 3'd4; upd_a = 1'b1;
      wait_busy_a(20, ok);
      upd_a = 1'b0;
      wait_done_a(bd + 2, 300, ok2);
      repeat (4) @(negedge clk);
      checks++;
      if (!ok2 || cap_a.size() - base != 43 || cap_a[base+7] !== 9'h104 || cap_a[base+42] !== 9'h11F) begin
         failures++;
         $display("FAIL mid_rerun: done_ok=%b count=%0d b7=%h b42=%h expected 1 43 104 11f", ok2, cap_a.size() - base, cap_a[base+7], cap_a[base+42]);
      end
   endtask

   task automatic test_corner_b();
      int base, bd, errs, pb, pc;
      bit ok;
      logic [8:0] hdr [11];
      hdr = '{9'h02A, 9'h100, 9'h1F0, 9'h100, 9'h1FF, 9'h02B, 9'h100, 9'h1F0, 9'h100, 9'h1FF, 9'h02C};
      base = cap_b.size(); bd = done_cnt_b;
      @(negedge clk);
      init_b = 1'b1;
      wait_busy_b(20, ok);
      init_b = 1'b0;
      wait_done_b(bd + 1, 300, ok);
      repeat (3) @(negedge clk);
      checks++;
      if (!ok || done_at_b - rise_at_b != 56 || capc_b[base+1] - capc_b[base] != 19) begin
         failures++;
         $display("FAIL corner_init: done_ok=%b latency=%0d gap=%0d expected 1 56 19", ok, done_at_b - rise_at_b, capc_b[base+1] - capc_b[base]);
      end
      base = cap_b.size(); pb = bad_ph_b; pc = ph_cnt_b;
      phase_en_b = 1'b1;
      @(negedge clk);
      x_b = 4'd15; y_b = 4'd15; obj_b = 3'd7; upd_b = 1'b1;
      wait_busy_b(20, ok);
      upd_b = 1'b0;
      wait_done_b(bd + 2, 4000, ok);
      repeat (2) @(negedge clk);
      phase_en_b = 1'b0;
      checks++;
      if (!ok || cap_b.size() - base != 523) begin
         failures++;
         $display("FAIL corner_count: done_ok=%b bytes=%0d expected 1 523", ok, cap_b.size() - base);
      end
      errs = 0;
      for (int i = 0; i < 11; i++) if (cap_b[base+i] !== hdr[i]) errs++;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL corner_window: wrong=%0d col=%h%h%h%h expected 0 wrong col=100 1f0 100 1ff", errs, cap_b[base+1], cap_b[base+2], cap_b[base+3], cap_b[base+4]);
      end
      errs = 0;
      for (int i = 0; i < 512; i++) if (cap_b[base+11+i] !== ((i % 2 == 0) ? 9'h1F8 : 9'h11F)) errs++;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL corner_pixels: wrong=%0d expected 0", errs);
      end
      checks++;
      if (done_at_b - rise_at_b != 3138) begin
         failures++;
         $display("FAIL corner_latency: got %0d expected 3138", done_at_b - rise_at_b);
      end
      checks++;
      if (bad_ph_b - pb != 0 || ph_cnt_b - pc != 1045) begin
         failures++;
         $display("FAIL corner_wr_phases: bad=%0d seen=%0d expected 0 1045", bad_ph_b - pb, ph_cnt_b - pc);
      end
   endtask

   initial begin
      test_reset();
      test_init_a();
      test_update_a();
      test_simultaneous_a();
      test_reset_mid_a();
      test_corner_b();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
